// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous RAM port between fetch (IF) and MEM loads/stores.
// Latency: word fetch/load done 5 cycles after acceptance (byte load 2), word store 4 (byte store 1).
// Backpressure: requests are levels held until done; stallreq_* freeze the pipeline meanwhile.
// Optional feature: define MEM_ARBITER_FETCH_FLUSH_EN to add if_flush, which abandons a fetch in RD.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_data,
  output logic                  if_done,
`ifdef MEM_ARBITER_FETCH_FLUSH_EN
  input  logic                  if_flush,
`endif
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [1:0]            mem_len,
  output logic [31:0]           mem_rdata,
  output logic                  mem_done,
  output logic                  stallreq_if,
  output logic                  stallreq_mem,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din,
  output logic                  ram_wr
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                state, state_n;
  logic [1:0]            cnt, cnt_n;       // byte index being written / captured
  logic [1:0]            last, last_n;     // byte count minus one
  logic                  primed, primed_n; // RAM read pipeline has filled
  logic                  sel_if, sel_if_n; // access belongs to the fetch side
  logic [ADDR_WIDTH-1:0] base, base_n;
  logic [31:0]           wdata, wdata_n;
  logic [31:0]           rbuf, rbuf_n;
  logic [ADDR_WIDTH-1:0] ram_addr_n;
  logic [7:0]            ram_dout_n;
  logic                  ram_wr_n;
  logic [31:0]           if_data_n, mem_rdata_n;
  logic                  if_done_n, mem_done_n;
  logic [1:0]            cnt_inc;

  assign cnt_inc = cnt + 2'd1;

`ifdef MEM_ARBITER_FETCH_FLUSH_EN
  assign stallreq_if = if_req & ~if_done & ~if_flush;
`else
  assign stallreq_if = if_req & ~if_done;
`endif
  assign stallreq_mem = mem_req & ~mem_done;

  // Next-state and next-output logic; all outputs are registered.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    last_n      = last;
    primed_n    = primed;
    sel_if_n    = sel_if;
    base_n      = base;
    wdata_n     = wdata;
    rbuf_n      = rbuf;
    ram_addr_n  = ram_addr;
    ram_dout_n  = ram_dout;
    ram_wr_n    = ram_wr;
    if_data_n   = if_data;
    mem_rdata_n = mem_rdata;
    if_done_n   = 1'b0;
    mem_done_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n    = 2'd0;
        primed_n = 1'b0;
        rbuf_n   = 32'd0;
        if (mem_req) begin
          // MEM wins over fetch; byte 0 goes out on the acceptance edge.
          sel_if_n   = 1'b0;
          base_n     = mem_addr;
          wdata_n    = mem_wdata;
          last_n     = mem_len;
          ram_addr_n = mem_addr;
          if (mem_we) begin
            ram_dout_n = mem_wdata[7:0];
            ram_wr_n   = 1'b1;
            state_n    = WR;
          end else begin
            state_n = RD;
          end
        end else if (if_req) begin
          sel_if_n   = 1'b1;
          base_n     = if_addr;
          last_n     = 2'd3;
          ram_addr_n = if_addr;
          state_n    = RD;
        end
      end
      RD: begin
`ifdef MEM_ARBITER_FETCH_FLUSH_EN
        if (sel_if && if_flush) begin
          state_n = IDLE;
        end else
`endif
        if (!primed) begin
          // First edge only lets the RAM sample byte 0; issue byte 1 if any.
          primed_n = 1'b1;
          if (last != 2'd0) ram_addr_n = base + ADDR_WIDTH'(1);
        end else begin
          rbuf_n[{cnt, 3'b000} +: 8] = ram_din;
          if (cnt == last) begin
            state_n = DONE;
            if (sel_if) begin
              if_data_n = rbuf_n;
              if_done_n = 1'b1;
            end else begin
              mem_rdata_n = rbuf_n;
              mem_done_n  = 1'b1;
            end
          end else begin
            cnt_n = cnt_inc;
            // Address runs two bytes ahead of the capture index.
            if (({1'b0, cnt} + 3'd2) <= {1'b0, last})
              ram_addr_n = base + ADDR_WIDTH'(cnt) + ADDR_WIDTH'(2);
          end
        end
      end
      WR: begin
        if (cnt == last) begin
          ram_wr_n   = 1'b0;
          mem_done_n = 1'b1;
          state_n    = DONE;
        end else begin
          cnt_n      = cnt_inc;
          ram_addr_n = base + ADDR_WIDTH'(cnt_inc);
          ram_dout_n = wdata[{cnt_inc, 3'b000} +: 8];
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      last      <= 2'd0;
      primed    <= 1'b0;
      sel_if    <= 1'b0;
      base      <= '0;
      wdata     <= 32'd0;
      rbuf      <= 32'd0;
      ram_addr  <= '0;
      ram_dout  <= 8'd0;
      ram_wr    <= 1'b0;
      if_data   <= 32'd0;
      mem_rdata <= 32'd0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      last      <= last_n;
      primed    <= primed_n;
      sel_if    <= sel_if_n;
      base      <= base_n;
      wdata     <= wdata_n;
      rbuf      <= rbuf_n;
      ram_addr  <= ram_addr_n;
      ram_dout  <= ram_dout_n;
      ram_wr    <= ram_wr_n;
      if_data   <= if_data_n;
      mem_rdata <= mem_rdata_n;
      if_done   <= if_done_n;
      mem_done  <= mem_done_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter against a byte-wide synchronous RAM model.
// Latency: n/a (bench).
// Backpressure: requests held until the matching done pulse.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic [31:0] if_data, mem_rdata, ram_addr;
  logic        if_done, mem_done, stallreq_if, stallreq_mem, ram_wr;
  logic [7:0]  ram_dout, ram_din;

  mem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_len(mem_len), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data for the sampled address appears after the edge.
  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr[11:0]] <= ram_dout;
    ram_din <= ram[ram_addr[11:0]];
  end

  // Log of every byte the RAM actually writes.
  logic [31:0] wlog_addr[$];
  logic [7:0]  wlog_dat[$];
  always @(posedge clk) begin
    if (ram_wr) begin
      wlog_addr.push_back(ram_addr);
      wlog_dat.push_back(ram_dout);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One access from an idle bus; returns cycles from acceptance to done (-1 on timeout).
  task automatic run_access(input logic is_if, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [1:0] len,
                            output int lat, output logic [31:0] data,
                            output logic stall_ok, output logic stall_at_done);
    lat = -1; data = 32'd0; stall_ok = 1'b1; stall_at_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd; mem_len = len;
    end
    @(posedge clk); #1;
    // Inputs after acceptance must be ignored.
    if_addr = ~addr; mem_addr = ~addr; mem_wdata = ~wd;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (is_if ? if_done : mem_done) begin
        lat = n;
        data = is_if ? if_data : mem_rdata;
        stall_at_done = is_if ? stallreq_if : stallreq_mem;
        break;
      end
      if (!(is_if ? stallreq_if : stallreq_mem)) stall_ok = 1'b0;
    end
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
  endtask

  int          lat, mem_n, if_n;
  logic [31:0] data;
  logic        sok, sdone, both, nodone;

  initial begin
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    if_addr = 32'd0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_len = 2'd0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h10; ram[12'h103] = 8'h00;
    ram[12'h205] = 8'h5A;
    ram[12'h300] = 8'h34; ram[12'h301] = 8'h82; ram[12'h302] = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_ram_dout", 64'(ram_dout), 64'd0);
    check("rst_ram_wr", 64'(ram_wr), 64'd0);
    check("rst_if_data", 64'(if_data), 64'd0);
    check("rst_mem_rdata", 64'(mem_rdata), 64'd0);
    check("rst_dones", 64'({if_done, mem_done}), 64'd0);
    rst = 1'b0;

    // Word fetch
    wlog_addr.delete(); wlog_dat.delete();
    run_access(1'b1, 1'b0, 32'h100, 32'd0, 2'd3, lat, data, sok, sdone);
    check("fetch_lat", 64'(lat), 64'd5);
    check("fetch_data", 64'(data), 64'h0010_0513);
    check("fetch_no_write", 64'(wlog_addr.size()), 64'd0);
    check("fetch_stall", 64'(sok), 64'd1);
    check("fetch_stall_done", 64'(sdone), 64'd0);

    // Byte store
    wlog_addr.delete(); wlog_dat.delete();
    run_access(1'b0, 1'b1, 32'h204, 32'hDEAD_BEEF, 2'd0, lat, data, sok, sdone);
    check("sb_lat", 64'(lat), 64'd1);
    check("sb_nwrites", 64'(wlog_addr.size()), 64'd1);
    check("sb_waddr", 64'(wlog_addr[0]), 64'h204);
    check("sb_wdat", 64'(wlog_dat[0]), 64'hEF);
    check("sb_ram204", 64'(ram[12'h204]), 64'hEF);
    check("sb_ram205", 64'(ram[12'h205]), 64'h5A);

    // Half load, zero-extended; fetch data must hold
    run_access(1'b0, 1'b0, 32'h300, 32'd0, 2'd1, lat, data, sok, sdone);
    check("lh_lat", 64'(lat), 64'd3);
    check("lh_data", 64'(data), 64'h0000_8234);
    check("lh_if_hold", 64'(if_data), 64'h0010_0513);

    // Byte load and 3-byte load
    run_access(1'b0, 1'b0, 32'h302, 32'd0, 2'd0, lat, data, sok, sdone);
    check("lb_lat", 64'(lat), 64'd2);
    check("lb_data", 64'(data), 64'h77);
    run_access(1'b0, 1'b0, 32'h100, 32'd0, 2'd2, lat, data, sok, sdone);
    check("l3_lat", 64'(lat), 64'd4);
    check("l3_data", 64'(data), 64'h0010_0513);

    // Contention: store word wins, fetch follows after DONE + IDLE
    repeat (2) @(posedge clk);
    #1;
    wlog_addr.delete(); wlog_dat.delete();
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h400; mem_wdata = 32'h1122_3344; mem_len = 2'd3;
    mem_n = -1; if_n = -1; both = 1'b0; sok = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (if_done && mem_done) both = 1'b1;
      if (mem_done) begin
        mem_n = n; mem_req = 1'b0; mem_we = 1'b0;
      end
      if (if_done) begin
        if_n = n; if_req = 1'b0;
        break;
      end
      if (!stallreq_if) sok = 1'b0;
    end
    if_req = 1'b0; mem_req = 1'b0;
    check("ct_mem_lat", 64'(mem_n), 64'd4);
    check("ct_if_lat", 64'(if_n), 64'd11);
    check("ct_one_done", 64'(both), 64'd0);
    check("ct_stall_if", 64'(sok), 64'd1);
    check("ct_nwrites", 64'(wlog_addr.size()), 64'd4);
    check("ct_ram400", 64'({ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]}), 64'h1122_3344);
    check("ct_if_data", 64'(if_data), 64'h0010_0513);

    // Wrapping word store
    wlog_addr.delete(); wlog_dat.delete();
    run_access(1'b0, 1'b1, 32'hFFFF_FFFE, 32'h1122_3344, 2'd3, lat, data, sok, sdone);
    check("wrap_lat", 64'(lat), 64'd4);
    check("wrap_nwrites", 64'(wlog_addr.size()), 64'd4);
    check("wrap_addrs", {wlog_addr[0], wlog_addr[1]}, 64'hFFFF_FFFE_FFFF_FFFF);
    check("wrap_addrs_hi", {wlog_addr[2], wlog_addr[3]}, 64'h0000_0000_0000_0001);
    check("wrap_data", 64'({wlog_dat[3], wlog_dat[2], wlog_dat[1], wlog_dat[0]}), 64'h1122_3344);

    // Same store, reset after byte 1 is written
    repeat (2) @(posedge clk);
    #1;
    wlog_addr.delete(); wlog_dat.delete();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'hFFFF_FFFE; mem_wdata = 32'hAABB_CCDD; mem_len = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rs_wr_before", 64'(ram_wr), 64'd1);
    rst = 1'b1;
    #1;
    check("rs_wr_async", 64'(ram_wr), 64'd0);
    check("rs_ram_addr", 64'(ram_addr), 64'd0);
    check("rs_mem_rdata", 64'(mem_rdata), 64'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    nodone = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (mem_done || ram_wr) nodone = 1'b0;
    end
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (mem_done || ram_wr) nodone = 1'b0;
    end
    check("rs_no_done", 64'(nodone), 64'd1);
    check("rs_nwrites", 64'(wlog_addr.size()), 64'd2);
    check("rs_ram_ffe", 64'({ram[12'hFFF], ram[12'hFFE]}), 64'hCCDD);
    check("rs_ram0", 64'(ram[12'h000]), 64'h22);

    // Recovery: fetch after reset
    run_access(1'b1, 1'b0, 32'h300, 32'd0, 2'd3, lat, data, sok, sdone);
    check("post_fetch_lat", 64'(lat), 64'd5);
    check("post_fetch_data", 64'(data), 64'h0077_8234);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
